// File: rtl/eth_tx_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : eth_tx_port_arbiter
//  Description : Packet-level round-robin arbiter merging N_PORTS MAC-side
//                source streams onto one switch-port stream. A source wins
//                on its sop beat and keeps the port until its eop beat moves.
//  Options     : ARB_STALL_TIMEOUT_EN - abort a packet whose granted source
//                stops presenting beats for TIMEOUT_CYC cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_port_arbiter #(
  parameter  int N_PORTS     = 4,
  parameter  int DATA_W      = 32,
  parameter  int TIMEOUT_CYC = 64,
  localparam int BV_W        = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS*DATA_W-1:0]   rx_data,
  input  logic [N_PORTS*BV_W-1:0]     rx_bv,
  input  logic [N_PORTS-1:0]          rx_sop,
  input  logic [N_PORTS-1:0]          rx_eop,
  input  logic [N_PORTS-1:0]          rx_valid,
  output logic [N_PORTS-1:0]          rx_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic [BV_W-1:0]             tx_bv,
  output logic                        tx_sop,
  output logic                        tx_eop,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [N_PORTS-1:0]          grant,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int                 c_GI_W = $clog2(N_PORTS);
  localparam logic [N_PORTS-1:0] c_ONE  = {{(N_PORTS-1){1'b0}}, 1'b1};

  // Elaboration-time guard against unsupported configurations.
  if (N_PORTS < 2 || N_PORTS > 8 || TIMEOUT_CYC < 1 || (DATA_W % 8) != 0) begin : g_param_check
    $error("eth_tx_port_arbiter: unsupported parameter set");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  state_t              r_state;
  logic [N_PORTS-1:0]  r_grant;
  logic [c_GI_W-1:0]   r_gidx;
  logic [c_GI_W-1:0]   r_rr_ptr;
  logic                r_busy;

  logic [N_PORTS-1:0]  w_req;
  logic                w_found;
  logic [c_GI_W-1:0]   w_pick;
  logic                w_g_valid;
  logic                w_eop_xfer;
  logic [c_GI_W-1:0]   w_next_ptr;

`ifdef ARB_STALL_TIMEOUT_EN
  localparam int                    c_STALL_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_STALL_W-1:0]  c_STALL_LIM = c_STALL_W'(TIMEOUT_CYC - 1);
  logic [c_STALL_W-1:0]  r_stall;
  logic                  r_tmo;
  assign timeout_err = r_tmo;
`else
  assign timeout_err = 1'b0;
`endif

  // Only a valid sop beat asks for the port; mid-packet beats never do.
  assign w_req      = rx_valid & rx_sop;
  assign w_g_valid  = rx_valid[r_gidx];
  assign w_eop_xfer = (r_state == ST_PKT) & w_g_valid & rx_eop[r_gidx] & tx_ready;
  assign w_next_ptr = (r_gidx == c_GI_W'(N_PORTS - 1)) ? '0 : r_gidx + 1'b1;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!w_found && w_req[(int'(r_rr_ptr) + k) % N_PORTS]) begin
        w_found = 1'b1;
        w_pick  = c_GI_W'((int'(r_rr_ptr) + k) % N_PORTS);
      end
    end
  end

  // Arbitration FSM: grant held from sop win until eop transfer (or stall abort).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
      r_busy   <= 1'b0;
`ifdef ARB_STALL_TIMEOUT_EN
      r_stall  <= '0;
      r_tmo    <= 1'b0;
`endif
    end else begin
`ifdef ARB_STALL_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_PKT;
            r_grant <= c_ONE << w_pick;
            r_gidx  <= w_pick;
            r_busy  <= 1'b1;
`ifdef ARB_STALL_TIMEOUT_EN
            r_stall <= '0;
`endif
          end
        end
        ST_PKT: begin
          if (w_eop_xfer) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
          end
`ifdef ARB_STALL_TIMEOUT_EN
          else if (!w_g_valid) begin
            if (r_stall == c_STALL_LIM) begin
              r_state  <= ST_IDLE;
              r_grant  <= '0;
              r_busy   <= 1'b0;
              r_rr_ptr <= w_next_ptr;
              r_stall  <= '0;
              r_tmo    <= 1'b1;
            end else begin
              r_stall <= r_stall + 1'b1;
            end
          end else begin
            r_stall <= '0;
          end
`endif
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Merged stream: straight mux of the granted source while a packet runs.
  always_comb begin
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;
    tx_data  = '0;
    tx_bv    = '0;
    if (r_state == ST_PKT) begin
      tx_valid = w_g_valid;
      tx_sop   = rx_sop[r_gidx];
      tx_eop   = rx_eop[r_gidx];
      tx_data  = rx_data[r_gidx*DATA_W +: DATA_W];
      tx_bv    = rx_bv[r_gidx*BV_W +: BV_W];
    end
  end

  assign rx_ready = (r_state == ST_PKT) ? (r_grant & {N_PORTS{tx_ready}}) : '0;
  assign grant    = r_grant;
  assign busy     = r_busy;

endmodule
`default_nettype wire
